// File: rtl/dobby_bus_responder.sv
// Bus target for the dobby core: word RAM, peripheral register window, timer and
// a two-line interrupt source, answering the en/wen/size/addr/ready handshake.
module dobby_bus_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        a_reset_h,
  input  logic        i_bus_en,
  input  logic        i_bus_wen,
  input  logic [1:0]  i_bus_size,
  input  logic [15:0] i_bus_addr,
  input  logic [31:0] i_store_data,
  input  logic [1:0]  i_intr_ack,
  output logic        o_bus_ready,
  output logic [31:0] o_load_data,
  output logic [1:0]  o_intr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, next_state;
  logic [3:0]  wait_cnt;
  logic        req_wen;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic [15:0] timer_cmp, timer_cnt;
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge a_reset_h) begin
    if (a_reset_h) state <= S_IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (i_bus_en) next_state = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (wait_cnt == 4'(WAIT_STATES - 1)) next_state = S_RESP;
      S_RESP: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_bus_ready = (state == S_RESP);
  end

  always_ff @(posedge clk or posedge a_reset_h) begin
    if (a_reset_h) begin
      wait_cnt <= '0;
      req_wen  <= 1'b0;
      req_size <= '0;
      req_addr <= '0;
      req_data <= '0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 4'd1 : 4'd0;
      if (state == S_IDLE && i_bus_en) begin
        req_wen  <= i_bus_wen;
        req_size <= i_bus_size;
        req_addr <= i_bus_addr;
        req_data <= i_store_data;
      end
    end
  end

  // With no wait states the commit edge is the IDLE sampling edge, so use the live bus.
  logic        eff_wen;
  logic [1:0]  eff_size;
  logic [15:0] eff_addr;
  logic [31:0] eff_data;
  assign eff_wen  = (state == S_IDLE) ? i_bus_wen    : req_wen;
  assign eff_size = (state == S_IDLE) ? i_bus_size   : req_size;
  assign eff_addr = (state == S_IDLE) ? i_bus_addr   : req_addr;
  assign eff_data = (state == S_IDLE) ? i_store_data : req_data;

  logic commit, is_reg, ok;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [31:0] ram_word, ram_shift, ram_rdata, ram_wdata, reg_rdata, load_next;
  logic [3:0]  ram_be;

  assign commit  = (next_state == S_RESP);
  assign is_reg  = eff_addr[15];
  assign ram_idx = eff_addr[DEPTH_LOG2+1:2];
  assign ram_word  = mem[ram_idx];
  assign ram_shift = ram_word >> {eff_addr[1:0], 3'b000};

  always_comb begin
    ok        = 1'b0;
    ram_be    = 4'b0000;
    ram_wdata = eff_data;
    ram_rdata = 32'h0;
    unique case (eff_size)
      2'b00: begin
        ok        = 1'b1;
        ram_be    = 4'b0001 << eff_addr[1:0];
        ram_wdata = {4{eff_data[7:0]}};
        ram_rdata = {24'h0, ram_shift[7:0]};
      end
      2'b01: begin
        ok        = ~eff_addr[0];
        ram_be    = eff_addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{eff_data[15:0]}};
        ram_rdata = {16'h0, ram_shift[15:0]};
      end
      2'b10: begin
        ok        = (eff_addr[1:0] == 2'b00);
        ram_be    = 4'b1111;
        ram_rdata = ram_word;
      end
      default: ok = 1'b0;
    endcase
    if (is_reg && eff_size != 2'b10) ok = 1'b0;
  end

  always_comb begin
    reg_rdata = 32'h0;
    case (eff_addr)
      16'h8000: reg_rdata = {16'h0, timer_cmp};
      16'h8004: reg_rdata = {16'h0, timer_cnt};
      16'h8008: reg_rdata = {30'h0, o_intr};
      default:  reg_rdata = 32'h0;
    endcase
  end

  assign load_next = (!ok || eff_wen) ? 32'h0 : (is_reg ? reg_rdata : ram_rdata);

  // A write must not slip through on an edge that arrives while reset is held.
  logic ram_we, reg_we, cmp_we, status_we, sw_we, timer_hit;
  assign ram_we    = commit && ok && eff_wen && !is_reg && !a_reset_h;
  assign reg_we    = commit && ok && eff_wen && is_reg;
  assign cmp_we    = reg_we && (eff_addr == 16'h8000);
  assign status_we = reg_we && (eff_addr == 16'h8008);
  assign sw_we     = reg_we && (eff_addr == 16'h800C);
  assign timer_hit = (timer_cmp != 16'h0) && (timer_cnt == timer_cmp);

  // NOTE: the RAM array has no reset; clearing it would force a flop-based memory.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge a_reset_h) begin
    if (a_reset_h) begin
      o_load_data <= 32'h0;
      timer_cmp   <= 16'h0;
      timer_cnt   <= 16'h0;
      o_intr      <= 2'b00;
    end else begin
      if (commit) o_load_data <= load_next;

      if (cmp_we) begin
        timer_cmp <= eff_data[15:0];
        timer_cnt <= 16'h0;
      end else if (timer_cmp == 16'h0 || timer_hit) begin
        timer_cnt <= 16'h0;
      end else begin
        timer_cnt <= timer_cnt + 16'd1;
      end

      // Set has priority over any clear arriving in the same cycle.
      o_intr <= (o_intr & ~(i_intr_ack | (status_we ? eff_data[1:0] : 2'b00)))
              | {sw_we & eff_data[0], timer_hit};
    end
  end

endmodule

// File: tb/tb_dobby_bus_responder.sv
// Randomised and directed bench for dobby_bus_responder against a byte-array memory
// model and hand-derived timer/interrupt expectations.
module tb_dobby_bus_responder;

  localparam int DEPTH_LOG2  = 8;
  localparam int WAIT_STATES = 1;
  localparam int NBYTES      = 4 << DEPTH_LOG2;

  logic        clk = 1'b0;
  logic        a_reset_h = 1'b1;
  logic        i_bus_en = 1'b0;
  logic        i_bus_wen = 1'b0;
  logic [1:0]  i_bus_size = 2'b00;
  logic [15:0] i_bus_addr = 16'h0;
  logic [31:0] i_store_data = 32'h0;
  logic [1:0]  i_intr_ack = 2'b00;
  logic        o_bus_ready;
  logic [31:0] o_load_data;
  logic [1:0]  o_intr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] ref_mem [NBYTES];

  dobby_bus_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(WAIT_STATES)) dut (
    .clk(clk), .a_reset_h(a_reset_h), .i_bus_en(i_bus_en), .i_bus_wen(i_bus_wen),
    .i_bus_size(i_bus_size), .i_bus_addr(i_bus_addr), .i_store_data(i_store_data),
    .i_intr_ack(i_intr_ack), .o_bus_ready(o_bus_ready), .o_load_data(o_load_data),
    .o_intr(o_intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RAM-region model: the byte array is the memory, addresses wrap at NBYTES.
  function automatic logic [31:0] model_ram(input bit wen, input logic [1:0] size,
                                            input logic [15:0] addr, input logic [31:0] data);
    int nb = 1 << size;
    int base;
    logic [31:0] r = 32'h0;
    if (size == 2'b11 || (int'(addr) % nb) != 0) return 32'h0;
    base = int'(addr) % NBYTES;
    for (int i = 0; i < nb; i++) begin
      if (wen) ref_mem[base + i] = data[8*i +: 8];
      else     r[8*i +: 8] = ref_mem[base + i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one transfer from IDLE, checks ready latency and pulse width, and for the
  // RAM region checks load data against the model. Returns one idle cycle later.
  task automatic do_xfer(input bit wen, input logic [1:0] size, input logic [15:0] addr,
                         input logic [31:0] data, output logic [31:0] rdata);
    int lat = 0;
    logic [31:0] exp;
    i_bus_en = 1'b1; i_bus_wen = wen; i_bus_size = size;
    i_bus_addr = addr; i_store_data = data;
    do begin
      tick();
      lat++;
    end while (!o_bus_ready && lat < 50);
    check("ready_latency", 32'(lat), 32'(1 + WAIT_STATES));
    rdata = o_load_data;
    i_bus_en = 1'b0;
    if (!addr[15]) begin
      exp = model_ram(wen, size, addr, data);
      if (!wen) check("ram_load", rdata, exp);
    end
    tick();
    check("ready_pulse", 32'(o_bus_ready), 32'h0);
  endtask

  task automatic ack_pulse(input logic [1:0] v);
    i_intr_ack = v;
    tick();
    i_intr_ack = 2'b00;
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] a;
    logic [1:0]  sz;
    int k;

    repeat (3) tick();
    check("rst_ready", 32'(o_bus_ready), 32'h0);
    check("rst_load", o_load_data, 32'h0);
    check("rst_intr", 32'(o_intr), 32'h0);
    a_reset_h = 1'b0;
    tick();

    for (int w = 0; w < (1 << DEPTH_LOG2); w++) do_xfer(1'b1, 2'b10, 16'(w * 4), $urandom, r);

    do_xfer(1'b1, 2'b10, 16'h0010, 32'h12345678, r);
    do_xfer(1'b0, 2'b10, 16'h0010, 32'h0, r);
    check("word_load_0010", r, 32'h12345678);

    do_xfer(1'b1, 2'b10, 16'h0020, 32'h0, r);
    do_xfer(1'b1, 2'b00, 16'h0023, 32'h000000AB, r);
    do_xfer(1'b1, 2'b01, 16'h0020, 32'h0000BEEF, r);
    do_xfer(1'b0, 2'b10, 16'h0020, 32'h0, r);
    check("merged_word", r, 32'hAB00BEEF);
    do_xfer(1'b0, 2'b00, 16'h0023, 32'h0, r);
    check("byte_load_0023", r, 32'h000000AB);

    do_xfer(1'b1, 2'b01, 16'h0021, 32'h00005555, r);
    do_xfer(1'b0, 2'b10, 16'h0020, 32'h0, r);
    check("misaligned_no_write", r, 32'hAB00BEEF);
    do_xfer(1'b0, 2'b10, 16'h0102, 32'h0, r);
    check("misaligned_load", r, 32'h0);
    do_xfer(1'b0, 2'b11, 16'h0020, 32'h0, r);
    check("reserved_size_load", r, 32'h0);
    do_xfer(1'b1, 2'b10, 16'h0400, 32'hCAFEF00D, r);
    do_xfer(1'b0, 2'b10, 16'h0000, 32'h0, r);
    check("alias_0400", r, 32'hCAFEF00D);

    do_xfer(1'b1, 2'b10, 16'h8000, 32'hABCD0005, r);
    do_xfer(1'b0, 2'b10, 16'h8000, 32'h0, r);
    check("cmp_readback", r, 32'h5);
    do_xfer(1'b1, 2'b10, 16'h8000, 32'h0, r);
    ack_pulse(2'b01);
    check("timer_off_intr", 32'(o_intr), 32'h0);
    do_xfer(1'b1, 2'b10, 16'h8004, 32'h1234, r);
    do_xfer(1'b0, 2'b10, 16'h8004, 32'h0, r);
    check("cnt_held_zero", r, 32'h0);

    // Compare value 5: the interrupt appears in the sixth cycle after the commit cycle.
    do_xfer(1'b1, 2'b10, 16'h8000, 32'h5, r);
    repeat (4) tick();
    check("timer_before_rise", 32'(o_intr[0]), 32'h0);
    tick();
    check("timer_rise", 32'(o_intr[0]), 32'h1);
    ack_pulse(2'b01);
    check("ack_clears", 32'(o_intr[0]), 32'h0);
    repeat (3) tick();
    check("timer_before_rerise", 32'(o_intr[0]), 32'h0);
    tick();
    ack_pulse(2'b01);
    check("set_beats_ack", 32'(o_intr[0]), 32'h1);
    do_xfer(1'b1, 2'b10, 16'h8000, 32'h0, r);
    ack_pulse(2'b01);
    check("timer_stopped", 32'(o_intr), 32'h0);

    do_xfer(1'b1, 2'b10, 16'h800C, 32'h1, r);
    check("sw_intr_set", 32'(o_intr), 32'h2);
    do_xfer(1'b0, 2'b10, 16'h8008, 32'h0, r);
    check("status_read", r, 32'h2);
    do_xfer(1'b0, 2'b10, 16'h800C, 32'h0, r);
    check("sw_reads_zero", r, 32'h0);
    do_xfer(1'b0, 2'b00, 16'h8008, 32'h0, r);
    check("reg_byte_load", r, 32'h0);
    ack_pulse(2'b01);
    check("ack_idle_line", 32'(o_intr), 32'h2);
    do_xfer(1'b1, 2'b10, 16'h8008, 32'h2, r);
    check("status_w1c", 32'(o_intr), 32'h0);

    do_xfer(1'b1, 2'b10, 16'h800C, 32'h1, r);
    do_xfer(1'b0, 2'b10, 16'h0010, 32'h0, r);
    i_bus_en = 1'b1; i_bus_wen = 1'b1; i_bus_size = 2'b10;
    i_bus_addr = 16'h0010; i_store_data = 32'hDEADBEEF;
    tick();
    check("wait_not_ready", 32'(o_bus_ready), 32'h0);
    a_reset_h = 1'b1;
    i_bus_en = 1'b0;
    #1;
    check("rst_async_ready", 32'(o_bus_ready), 32'h0);
    check("rst_async_load", o_load_data, 32'h0);
    check("rst_async_intr", 32'(o_intr), 32'h0);
    repeat (2) tick();
    check("rst_hold_ready", 32'(o_bus_ready), 32'h0);
    a_reset_h = 1'b0;
    tick();
    do_xfer(1'b0, 2'b10, 16'h0010, 32'h0, r);
    check("aborted_store", r, 32'h12345678);

    for (int n = 0; n < 300; n++) begin
      k  = $urandom_range(0, 9);
      sz = (k < 3) ? 2'b00 : (k < 6) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11;
      a  = 16'($urandom_range(0, 16'h7FFF));
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~16'((1 << sz) - 1);
      do_xfer(1'($urandom_range(0, 1)), sz, a, $urandom, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
